data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 256, size of storage in 64-bit doublewords (power of two).
REQ-002 SHALL have parameter LATENCY, default 2, wait cycles between request acceptance and response (0..15).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  1  processor presents an access.
REQ-006 SHALL have port req_ready  output  1  responder accepts the access this cycle.
REQ-007 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_addr  input  64  byte address.
REQ-009 SHALL have port req_size  input  2  00 byte, 01 half, 10 word, 11 doubleword.
REQ-010 SHALL have port req_signed  input  1  sign-extend load data when 1, zero-extend when 0.
REQ-011 SHALL have port req_wdata  input  64  store data, right-aligned (bits [8*n-1:0] used).
REQ-012 SHALL have port rsp_valid  output  1  response available.
REQ-013 SHALL have port rsp_ready  input  1  processor consumes the response.
REQ-014 SHALL have port rsp_rdata  output  64  load data, extended per req_signed; 0 for stores and errors.
REQ-015 SHALL have port rsp_err  output  1  access faulted; valid only with rsp_valid.

Function
REQ-016 SHALL implement FSM IDLE -> WAIT -> RESP -> IDLE; req_ready = 1 only in IDLE.
REQ-017 SHALL accept a request on a cycle with req_valid & req_ready, capturing we, addr, size, signed, wdata.
REQ-018 SHALL, on acceptance, load a wait counter with LATENCY and go to WAIT; with LATENCY = 0 go directly to RESP.
REQ-019 SHALL decrement the counter in WAIT and enter RESP the cycle after it reaches 1 (exactly LATENCY cycles in WAIT).
REQ-020 SHALL perform the storage read/write on the WAIT->RESP (or IDLE->RESP) transition, never earlier.
REQ-021 SHALL store little-endian: doubleword index addr[3 +: log2(DEPTH)], byte lane addr[2:0]; a store writes only the 1/2/4/8 addressed bytes.
REQ-022 SHALL flag rsp_err when addr[63:3] >= DEPTH (out of range); faulted stores SHALL not modify storage.
REQ-023 SHALL hold rsp_valid, rsp_rdata, rsp_err stable in RESP until rsp_ready = 1, then return to IDLE the next cycle.
REQ-024 SHALL ignore req_valid in WAIT and RESP (no queuing); earliest next acceptance is the cycle after the RESP handshake.
REQ-025 SHALL drive rsp_valid = 0 and rsp_rdata = 0 outside RESP.

Reset
REQ-026 SHALL, on reset assertion, immediately force IDLE, counter 0, req_ready = 1 after release, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
REQ-027 SHALL abandon an in-flight access on reset mid-operation; a pending store SHALL not be written.
REQ-028 SHALL not clear storage contents on reset.

Configuration
REQ-029 SHALL, with macro DATA_MEM_MISALIGN_CHECK_EN defined, flag rsp_err and suppress the access when addr is not naturally aligned to size (half: addr[0]; word: addr[1:0]; double: addr[2:0] nonzero).
REQ-030 SHALL, without DATA_MEM_MISALIGN_CHECK_EN, ignore low address bits below the access size (force alignment) and never flag misalignment.

Structure
REQ-031 SHALL take access-size encoding enum (SIZE_B, SIZE_H, SIZE_W, SIZE_D) and FSM state enum from shared package proc_pkg.
REQ-032 SHALL place byte-lane select, store merge and load extension in one combinational sub-module mem_lane_align.

Verification
REQ-033 Store double 0x1122334455667788 at 0x10, then load double 0x10 -> rsp_rdata 0x1122334455667788, rsp_err 0, rsp_valid exactly LATENCY+1 cycles after acceptance.
REQ-034 Load byte 0x17 signed after REQ-033 store -> rsp_rdata 0x0000000000000011; store byte 0x80 at 0x17 then load signed -> 0xFFFFFFFFFFFFFF80, unsigned -> 0x80.
REQ-035 Load word at 0x12 with DATA_MEM_MISALIGN_CHECK_EN -> rsp_err 1, rsp_rdata 0; without it -> data from 0x10 (0x55667788), rsp_err 0.
REQ-036 Store to addr 8*DEPTH -> rsp_err 1; subsequent load of 0x0 unchanged.
REQ-037 Hold rsp_ready 0 for 5 cycles in RESP -> rsp_valid/rsp_rdata stable, req_ready 0, second req_valid ignored.
REQ-038 Assert reset during WAIT of a store to 0x20 -> rsp_valid 0 at once, later load of 0x20 returns prior value.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared processor types: access-size encoding and
// data-memory responder FSM states.
package proc_pkg;

  typedef enum logic [1:0] {
    SIZE_B = 2'b00,
    SIZE_H = 2'b01,
    SIZE_W = 2'b10,
    SIZE_D = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane select, store merge and load extension for one
// little-endian 64-bit doubleword; low lane bits are forced aligned.
module mem_lane_align
  import proc_pkg::*;
(
  input  size_e       size_i,
  input  logic        sign_i,
  input  logic [2:0]  lane_i,
  input  logic [63:0] wdata_i,
  input  logic [63:0] rword_i,
  output logic [63:0] wword_o,
  output logic [63:0] rdata_o
);

  logic [5:0]  sh;
  logic [63:0] mask;
  logic [63:0] raw;
  logic        msb;

  // Shift/mask from size, then merge store bytes and extend load bytes.
  always_comb begin
    sh   = '0;
    mask = '0;
    msb  = 1'b0;
    unique case (size_i)
      SIZE_B: begin
        sh   = {lane_i, 3'b000};
        mask = 64'h0000_0000_0000_00FF;
      end
      SIZE_H: begin
        sh   = {lane_i[2:1], 4'b0000};
        mask = 64'h0000_0000_0000_FFFF;
      end
      SIZE_W: begin
        sh   = {lane_i[2], 5'b00000};
        mask = 64'h0000_0000_FFFF_FFFF;
      end
      SIZE_D: begin
        sh   = '0;
        mask = '1;
      end
      default: ;
    endcase
    wword_o = (rword_i & ~(mask << sh))
            | ((wdata_i & mask) << sh);
    raw = (rword_i >> sh) & mask;
    unique case (size_i)
      SIZE_B:  msb = raw[7];
      SIZE_H:  msb = raw[15];
      SIZE_W:  msb = raw[31];
      SIZE_D:  msb = raw[63];
      default: msb = 1'b0;
    endcase
    rdata_o = (sign_i && msb) ? (raw | ~mask) : raw;
  end

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding data memory with fixed response latency.
// Optional macro DATA_MEM_MISALIGN_CHECK_EN faults misaligned accesses.
module data_mem_responder
  import proc_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [63:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int          IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  LAT = 4'(LATENCY);
  localparam logic [60:0] DW  = 61'(DEPTH);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q;
  logic [63:0] addr_q;
  size_e       size_q;
  logic        sgn_q;
  logic [63:0] wdata_q;
  logic [63:0] rdata_q;
  logic        err_q;

  logic [63:0] mem_q [DEPTH];

  logic          accept;
  logic          access;
  logic          idle;
  logic          a_we;
  logic [63:0]   a_addr;
  size_e         a_size;
  logic          a_sgn;
  logic [63:0]   a_wdata;
  logic [IW-1:0] a_idx;
  logic          oor;
  logic          mis;
  logic          fault;
  logic          mem_we;
  logic [63:0]   rword;
  logic [63:0]   wword;
  logic [63:0]   ldata;

  assign idle      = (state_q == ST_IDLE);
  assign req_ready = idle && !reset;
  assign accept    = req_valid && req_ready;

  // With zero latency the access uses the live request.
  assign a_we    = idle ? req_we : we_q;
  assign a_addr  = idle ? req_addr : addr_q;
  assign a_size  = idle ? size_e'(req_size) : size_q;
  assign a_sgn   = idle ? req_signed : sgn_q;
  assign a_wdata = idle ? req_wdata : wdata_q;
  assign a_idx   = a_addr[3 +: IW];
  assign oor     = (a_addr[63:3] >= DW);

`ifdef DATA_MEM_MISALIGN_CHECK_EN
  // Natural alignment check per access size.
  always_comb begin
    mis = 1'b0;
    unique case (a_size)
      SIZE_B:  mis = 1'b0;
      SIZE_H:  mis = a_addr[0];
      SIZE_W:  mis = |a_addr[1:0];
      SIZE_D:  mis = |a_addr[2:0];
      default: mis = 1'b0;
    endcase
  end
`else
  assign mis = 1'b0;
`endif

  assign fault  = oor || mis;
  assign mem_we = access && a_we && !fault && !reset;
  assign rword  = mem_q[a_idx];

  mem_lane_align u_align (
    .size_i  (a_size),
    .sign_i  (a_sgn),
    .lane_i  (a_addr[2:0]),
    .wdata_i (a_wdata),
    .rword_i (rword),
    .wword_o (wword),
    .rdata_o (ldata)
  );

  // Next state, wait counter and access strobe.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    access  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (LAT == 4'd0) begin
            state_d = ST_RESP;
            access  = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = LAT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q <= 4'd1) begin
          state_d = ST_RESP;
          cnt_d   = '0;
          access  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control state, captured request and registered response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      size_q  <= SIZE_B;
      sgn_q   <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        size_q  <= size_e'(req_size);
        sgn_q   <= req_signed;
        wdata_q <= req_wdata;
      end
      if (access) begin
        rdata_q <= (a_we || fault) ? '0 : ldata;
        err_q   <= fault;
      end
    end
  end

  // Storage survives reset; writes only on a committed store.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[a_idx] <= wword;
  end

  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rsp_valid ? rdata_q : '0;
  assign rsp_err   = rsp_valid ? err_q : 1'b0;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed table, corner sequences
// and random traffic against a byte-array reference model.
module tb_data_mem_responder;

  localparam int DEPTH   = 256;
  localparam int LATENCY = 2;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [63:0] req_addr;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [63:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_rdata;
  logic        rsp_err;

  int checks;
  int errors;

  logic [7:0] mb [DEPTH*8];

  typedef struct {
    logic        we;
    logic [63:0] addr;
    logic [1:0]  sz;
    logic        sg;
    logic [63:0] wd;
    logic [63:0] ed;
    logic        ee;
  } vec_t;

  vec_t tbl [14];

  data_mem_responder #(
    .DEPTH   (DEPTH),
    .LATENCY (LATENCY)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", nm, got, exp);
    end
  endtask

  // Reference: memory as a flat byte array, access rules as arithmetic.
  task automatic model(input logic we, input logic [63:0] addr,
                       input logic [1:0] sz, input logic sg,
                       input logic [63:0] wd,
                       output logic [63:0] ed, output logic ee);
    longint unsigned a;
    longint unsigned v;
    int n;
    n  = 1 << sz;
    a  = addr;
    ee = 1'b0;
    ed = '0;
`ifdef DATA_MEM_MISALIGN_CHECK_EN
    if ((a % 64'(n)) != 0) ee = 1'b1;
`else
    a = a - (a % 64'(n));
`endif
    if (a / 8 >= 64'(DEPTH)) ee = 1'b1;
    if (!ee) begin
      if (we) begin
        for (int i = 0; i < n; i++)
          mb[int'(a) + i] = 8'(wd >> (8 * i));
      end else begin
        v = 0;
        for (int i = 0; i < n; i++)
          v = v | (64'(mb[int'(a) + i]) << (8 * i));
        if (sg && n < 8 && v[8*n-1])
          v = v | (~64'd0 << (8 * n));
        ed = v;
      end
    end
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < 40);
    chk("rsp_valid_seen", 64'(rsp_valid), 64'd1);
  endtask

  task automatic drive(input logic we, input logic [63:0] addr,
                       input logic [1:0] sz, input logic sg,
                       input logic [63:0] wd);
    req_we     = we;
    req_addr   = addr;
    req_size   = sz;
    req_signed = sg;
    req_wdata  = wd;
    req_valid  = 1'b1;
  endtask

  task automatic do_req(input logic we, input logic [63:0] addr,
                        input logic [1:0] sz, input logic sg,
                        input logic [63:0] wd,
                        output logic [63:0] rd, output logic er);
    int n;
    @(negedge clk);
    chk("req_ready_idle", 64'(req_ready), 64'd1);
    drive(we, addr, sz, sg, wd);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    wait_valid(n);
    chk("latency", 64'(n), 64'(LATENCY + 1));
    rd = rsp_rdata;
    er = rsp_err;
    @(posedge clk);
  endtask

  task automatic run_checked(input string nm, input logic we,
                             input logic [63:0] addr,
                             input logic [1:0] sz, input logic sg,
                             input logic [63:0] wd);
    logic [63:0] ed, rd;
    logic        ee, er;
    model(we, addr, sz, sg, wd, ed, ee);
    do_req(we, addr, sz, sg, wd, rd, er);
    chk({nm, "_rdata"}, rd, ed);
    chk({nm, "_err"}, 64'(er), 64'(ee));
  endtask

  initial begin
    logic [63:0] rd, ed, tmp;
    logic        er, ee;
    logic [63:0] ad;
    logic [1:0]  sz;
    int          n;

    checks = 0;
    errors = 0;

    tbl[0]  = '{1'b1, 64'h00, 2'd3, 1'b0, 64'hA5A5_5A5A_0123_4567,
                64'h0, 1'b0};
    tbl[1]  = '{1'b1, 64'h10, 2'd3, 1'b0, 64'h1122_3344_5566_7788,
                64'h0, 1'b0};
    tbl[2]  = '{1'b0, 64'h10, 2'd3, 1'b0, 64'h0,
                64'h1122_3344_5566_7788, 1'b0};
    tbl[3]  = '{1'b0, 64'h17, 2'd0, 1'b1, 64'h0,
                64'h0000_0000_0000_0011, 1'b0};
    tbl[4]  = '{1'b1, 64'h17, 2'd0, 1'b0, 64'h80, 64'h0, 1'b0};
    tbl[5]  = '{1'b0, 64'h17, 2'd0, 1'b1, 64'h0,
                64'hFFFF_FFFF_FFFF_FF80, 1'b0};
    tbl[6]  = '{1'b0, 64'h17, 2'd0, 1'b0, 64'h0, 64'h80, 1'b0};
    tbl[7]  = '{1'b0, 64'h16, 2'd1, 1'b1, 64'h0,
                64'hFFFF_FFFF_FFFF_8022, 1'b0};
    tbl[8]  = '{1'b0, 64'h14, 2'd2, 1'b1, 64'h0,
                64'hFFFF_FFFF_8022_3344, 1'b0};
`ifdef DATA_MEM_MISALIGN_CHECK_EN
    tbl[9]  = '{1'b0, 64'h12, 2'd2, 1'b0, 64'h0, 64'h0, 1'b1};
`else
    tbl[9]  = '{1'b0, 64'h12, 2'd2, 1'b0, 64'h0,
                64'h5566_7788, 1'b0};
`endif
    tbl[10] = '{1'b1, 64'(8 * DEPTH), 2'd3, 1'b0,
                64'hDEAD_BEEF_DEAD_BEEF, 64'h0, 1'b1};
    tbl[11] = '{1'b0, 64'h00, 2'd3, 1'b0, 64'h0,
                64'hA5A5_5A5A_0123_4567, 1'b0};
    tbl[12] = '{1'b1, 64'(8 * DEPTH - 2), 2'd1, 1'b0, 64'hBEEF,
                64'h0, 1'b0};
    tbl[13] = '{1'b0, 64'(8 * DEPTH - 2), 2'd1, 1'b0, 64'h0,
                64'hBEEF, 1'b0};

    reset      = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = '0;
    req_size   = '0;
    req_signed = 1'b0;
    req_wdata  = '0;
    rsp_ready  = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_rsp_rdata", rsp_rdata, 64'd0);
    chk("reset_rsp_err", 64'(rsp_err), 64'd0);
    reset = 1'b0;
    #1 chk("release_req_ready", 64'(req_ready), 64'd1);

    for (int i = 0; i < 8; i++) begin
      tmp = {$urandom, $urandom};
      run_checked("prefill", 1'b1, 64'(8 * i), 2'd3, 1'b0, tmp);
    end

    for (int i = 0; i < 14; i++) begin
      model(tbl[i].we, tbl[i].addr, tbl[i].sz, tbl[i].sg,
            tbl[i].wd, ed, ee);
      do_req(tbl[i].we, tbl[i].addr, tbl[i].sz, tbl[i].sg,
             tbl[i].wd, rd, er);
      chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].ed);
      chk($sformatf("tbl%0d_err", i), 64'(er), 64'(tbl[i].ee));
    end

    // Stalled response: stable outputs, second request ignored.
    model(1'b0, 64'h10, 2'd3, 1'b0, 64'h0, ed, ee);
    @(negedge clk);
    drive(1'b0, 64'h10, 2'd3, 1'b0, 64'h0);
    rsp_ready = 1'b0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    wait_valid(n);
    for (int k = 0; k < 5; k++) begin
      chk("stall_valid", 64'(rsp_valid), 64'd1);
      chk("stall_rdata", rsp_rdata, ed);
      chk("stall_req_ready", 64'(req_ready), 64'd0);
      drive(1'b1, 64'h0, 2'd3, 1'b0, 64'h0BAD_0BAD_0BAD_0BAD);
      @(negedge clk);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("post_hs_valid", 64'(rsp_valid), 64'd0);
    chk("post_hs_ready", 64'(req_ready), 64'd1);
    run_checked("ignored_store", 1'b0, 64'h0, 2'd3, 1'b0, 64'h0);

    // Reset while a store is waiting: the store is dropped.
    @(negedge clk);
    drive(1'b1, 64'h20, 2'd3, 1'b0, 64'hCAFE_F00D_CAFE_F00D);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_wait_valid", 64'(rsp_valid), 64'd0);
    chk("rst_wait_rdata", rsp_rdata, 64'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1 chk("rst_wait_ready", 64'(req_ready), 64'd1);
    run_checked("rst_store_dropped", 1'b0, 64'h20, 2'd3, 1'b0, 64'h0);

    // Reset while a response is being held.
    @(negedge clk);
    drive(1'b0, 64'h10, 2'd3, 1'b0, 64'h0);
    rsp_ready = 1'b0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    wait_valid(n);
    reset = 1'b1;
    #1;
    chk("rst_resp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_resp_rdata", rsp_rdata, 64'd0);
    chk("rst_resp_err", 64'(rsp_err), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    run_checked("after_rst_load", 1'b0, 64'h10, 2'd3, 1'b0, 64'h0);

    for (int i = 0; i < 300; i++) begin
      sz = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 15))
        0:       ad = 64'(8 * DEPTH) + 64'($urandom_range(0, 4095));
        1:       ad = {$urandom, $urandom} | 64'h8000_0000_0000_0000;
        default: ad = 64'($urandom_range(0, 63));
      endcase
      tmp = {$urandom, $urandom};
      run_checked("rand", 1'($urandom_range(0, 1)), ad, sz,
                  1'($urandom_range(0, 1)), tmp);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
